// File: rtl/boot_load_ctrl.sv
// Start-up sequencer for the single-cycle core: holds the core in reset while a
// loader streams an image into dmem, then hands the dmem write port to the core.
module boot_load_ctrl #(
  parameter logic [31:0] BASE  = 32'h0000_0000,
  parameter int          WORDS = 64,
  parameter int          LEN_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_start,
  input  logic [LEN_W-1:0] ld_len,
  input  logic             ld_run,
  input  logic             ld_valid,
  input  logic [31:0]      ld_data,
  output logic             ld_ready,
  input  logic             cpu_MemWrite,
  input  logic [31:0]      cpu_DataAdr,
  input  logic [31:0]      cpu_WriteData,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  localparam logic [LEN_W-1:0] WORDS_L = LEN_W'(WORDS);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  logic [1:0]       state_r;
  logic [LEN_W-1:0] idx_r;
  logic [LEN_W-1:0] len_r;
  logic             err_r;
  logic             done_r;

  logic             len_ok_s;
  logic             xfer_s;
  logic             last_s;

  // Request validation and transfer qualification.
  always_comb begin
    len_ok_s = (ld_len >= ONE_L) && (ld_len <= WORDS_L);
    xfer_s   = (state_r == ST_LOAD) && ld_valid;
    last_s   = (idx_r == (len_r - ONE_L));
  end

  // Sequencer state, word index, sampled length and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_HOLD;
      idx_r   <= '0;
      len_r   <= '0;
      err_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_HOLD, ST_RUN: begin
          if (ld_start) begin
            if (len_ok_s) begin
              state_r <= ST_LOAD;
              len_r   <= ld_len;
              idx_r   <= '0;
              err_r   <= 1'b0;
            end else begin
              err_r <= 1'b1;
            end
          end else if (ld_run && (state_r == ST_HOLD)) begin
            state_r <= ST_RUN;
          end
        end
        ST_LOAD: begin
          if (xfer_s) begin
            idx_r <= idx_r + ONE_L;
            if (last_s) begin
              state_r <= ST_RELEASE;
              done_r  <= 1'b1;
            end
          end
        end
        ST_RELEASE: state_r <= ST_RUN;
        default:    state_r <= ST_HOLD;
      endcase
    end
  end

  // Memory port mux: loader owns it during LOAD, core only during RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    case (state_r)
      ST_LOAD: begin
        if (xfer_s) begin
          mem_we    = 1'b1;
          mem_addr  = BASE + (32'(idx_r) << 2);
          mem_wdata = ld_data;
        end else begin
          mem_we = 1'b0;
        end
      end
      ST_RUN: begin
        mem_we    = cpu_MemWrite;
        mem_addr  = cpu_DataAdr;
        mem_wdata = cpu_WriteData;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  assign cpu_reset = (state_r != ST_RUN);
  assign ld_ready  = (state_r == ST_LOAD);
  assign busy      = (state_r == ST_LOAD);
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: doc/boot_load_ctrl.md
Name: boot_load_ctrl

Overview:
- Sequences start-up of the single-cycle RISC-V core.
- Holds the core in reset while an external loader streams a program or data image into the shared data-memory write port, then releases the core.
- While the core runs, it owns the memory port. This block is the single owner of the memory write mux between the loader and the core.
- Sits in the top level, between riscvsingle's memory signals (MemWrite, DataAdr, WriteData) and dmem.

Parameters:
- BASE, 32'h0000_0000: byte address of the first loaded word.
- WORDS, 64: maximum image length in 32-bit words.
- LEN_W, 7: width of ld_len; must satisfy 2^LEN_W > WORDS.

Ports:
- clk  in  1: system clock.
- reset  in  1: synchronous, active-high.
- ld_start  in  1: one-cycle request to begin a load.
- ld_len  in  LEN_W: number of words to load, sampled with ld_start.
- ld_run  in  1: release the core without loading. Honoured only in HOLD.
- ld_valid  in  1: loader word valid.
- ld_data  in  32: loader word.
- ld_ready  out  1: block accepts a word.
- cpu_MemWrite  in  1: core write enable.
- cpu_DataAdr  in  32: core address.
- cpu_WriteData  in  32: core write data.
- mem_we  out  1: write enable to dmem.
- mem_addr  out  32: address to dmem.
- mem_wdata  out  32: write data to dmem.
- cpu_reset  out  1: reset to the core, active-high.
- busy  out  1: high in LOAD.
- done  out  1: one-cycle pulse when a load completes.
- err  out  1: sticky; set when a load request is rejected.

Behaviour:
- Clock and reset: single clock domain (clk). reset is synchronous and active-high and overrides every other input in the cycle it is sampled.
- Reset state: state=HOLD, idx=0, len_q=0, err=0, done=0. Outputs in HOLD: cpu_reset=1, ld_ready=0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0.
- States: HOLD, LOAD, RELEASE, RUN. All state, idx, len_q, err and done are registered. ld_ready, mem_* and cpu_reset are decoded from registered state; mem_we also uses the live ld_valid / cpu_MemWrite.
- HOLD:
  - cpu_reset=1.
  - A valid ld_start → LOAD, len_q<=ld_len, idx<=0.
  - Else ld_run → RUN.
  - ld_start takes priority over ld_run in the same cycle.
- Valid ld_start: 1 <= ld_len <= WORDS.
  - An invalid ld_start sets err, leaves state unchanged, and does not change len_q.
  - A valid ld_start clears err.
- LOAD:
  - cpu_reset=1, ld_ready=1, busy=1.
  - Transfer occurs when ld_valid & ld_ready.
  - On a transfer, in the same cycle (combinational): mem_we=1, mem_addr=BASE+4*idx, mem_wdata=ld_data.
  - With no transfer, mem_we=0.
  - idx increments on each transfer. On the transfer where idx==len_q-1 → RELEASE.
  - ld_start and ld_run are ignored in LOAD.
- RELEASE: one cycle. cpu_reset=1, ld_ready=0, mem_we=0, done=1 (registered pulse, visible in this cycle only). Next state is RUN.
- RUN:
  - cpu_reset=0, ld_ready=0.
  - mem_we=cpu_MemWrite, mem_addr=cpu_DataAdr, mem_wdata=cpu_WriteData, combinationally.
  - A valid ld_start → LOAD (reload) with cpu_reset reasserted from the next cycle. The core keeps the port in the ld_start cycle.
  - An invalid ld_start sets err and stays in RUN.
  - ld_run is ignored.
- Core writes are never forwarded outside RUN.
- Address arithmetic: mod 2^32, no overflow check.
- idx width: LEN_W.
- Reset mid-LOAD: abort to HOLD, idx=0. Words already written stay in memory. No done pulse.

Test Plan:
- Post-reset idle: assert reset for 2 cycles, release, toggle cpu_MemWrite=1 → cpu_reset=1, mem_we=0, ld_ready=0, err=0 for 10 cycles.
- Three-word load: BASE=0, ld_start with ld_len=3; stream 0x11,0x22,0x33 with ld_valid gapped as 1,0,1,1 → writes to addr 0x0, 0x4, 0x8 only on valid cycles; done pulses exactly once, in the cycle after the third transfer; cpu_reset falls in the following cycle.
- Bad length: ld_start with ld_len=0, then ld_len=65 (WORDS=64) → err=1, state stays HOLD; a later ld_start with ld_len=1 clears err and enters LOAD.
- Run mux: ld_run in HOLD; in RUN drive cpu_MemWrite=1, cpu_DataAdr=0x40, cpu_WriteData=0xDEADBEEF → mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF in the same cycle.
- Reload from RUN: in RUN, ld_start with ld_len=2 → cpu_reset=1 from the next cycle; cpu_MemWrite is ignored during LOAD; two words land at 0x0 and 0x4; RUN resumes after RELEASE.
- Reset mid-load: ld_len=4, reset asserted after 2 transfers → HOLD, no done pulse; a new load of 1 word writes to 0x0 (idx restarted).
